// File: rtl/gemv_lanes.sv
// gemv_lanes: tiled matrix-vector multiply computing LANES rows per group, with weights streamed one tile per handshake.
// Optional build macro GEMV_LANES_RELU_EN clamps every presented output to max(acc+bias, 0).
module gemv_lanes #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int TILE_SIZE  = 32,
    parameter int LANES      = 4,
    parameter int MAX_ROWS   = 1024,
    parameter int MAX_COLS   = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [15:0]                           rows,
    input  logic [15:0]                           cols,
    input  logic [MAX_COLS*DATA_WIDTH-1:0]        x,
    input  logic [MAX_ROWS*DATA_WIDTH-1:0]        bias,
    input  logic                                  w_valid,
    output logic                                  w_ready,
    input  logic [LANES*TILE_SIZE*DATA_WIDTH-1:0] w_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [ACC_WIDTH-1:0]           out_data,
    output logic [15:0]                           out_idx,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    localparam int CW  = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam int RW  = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
    localparam int LCW = $clog2(LANES + 1);
    localparam logic [31:0] MAX_ROWS_U = 32'(MAX_ROWS);
    localparam logic [31:0] MAX_COLS_U = 32'(MAX_COLS);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_DONE} state_t;

    state_t state, state_nx;

    logic [15:0]                 rows_r, cols_r;
    logic [15:0]                 col_base;
    logic [16:0]                 row_base;
    logic [LCW-1:0]              lane_cnt;
    logic signed [ACC_WIDTH-1:0] acc [LANES];
    logic signed [ACC_WIDTH-1:0] dot [LANES];
    logic signed [ACC_WIDTH-1:0] tile_sum_p0 [LANES];
    logic signed [ACC_WIDTH-1:0] sel_acc;
    logic signed [DATA_WIDTH-1:0] x_arr [MAX_COLS];
    logic signed [DATA_WIDTH-1:0] bias_arr [MAX_ROWS];

    logic        bad_dims, tile_last, grp_last, drain_end;
    logic [16:0] row_cur;

    for (genvar c = 0; c < MAX_COLS; c++) begin : g_x
        assign x_arr[c] = x[c*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar r = 0; r < MAX_ROWS; r++) begin : g_bias
        assign bias_arr[r] = bias[r*DATA_WIDTH +: DATA_WIDTH];
    end

    function automatic logic signed [ACC_WIDTH-1:0] finish_out(
        input logic signed [ACC_WIDTH-1:0]  a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [ACC_WIDTH-1:0] s;
        s = a + {{(ACC_WIDTH-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
`ifdef GEMV_LANES_RELU_EN
        if (s[ACC_WIDTH-1]) s = '0;
`endif
        return s;
    endfunction

    assign bad_dims  = (rows == 16'd0) || (cols == 16'd0) ||
                       (32'(rows) > MAX_ROWS_U) || (32'(cols) > MAX_COLS_U);
    assign tile_last = ({1'b0, col_base} + 17'(TILE_SIZE)) >= {1'b0, cols_r};
    assign grp_last  = (row_base + 17'(LANES)) >= {1'b0, rows_r};
    assign row_cur   = row_base + 17'(lane_cnt);
    assign drain_end = (lane_cnt == LCW'(LANES)) || (row_cur >= {1'b0, rows_r});

    assign w_ready = (state == S_LOAD);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    // Per-lane tile dot product; columns at or beyond cols are masked to zero.
    always_comb begin : dot_calc
        logic signed [DATA_WIDTH-1:0]   xv;
        logic signed [DATA_WIDTH-1:0]   wv;
        logic signed [2*DATA_WIDTH-1:0] prod;
        xv   = '0;
        wv   = '0;
        prod = '0;
        for (int l = 0; l < LANES; l++) begin
            dot[l] = '0;
            for (int i = 0; i < TILE_SIZE; i++) begin
                xv = (({1'b0, col_base} + 17'(i)) < {1'b0, cols_r}) ?
                     x_arr[CW'(col_base + 16'(i))] : '0;
                wv = w_data[(l*TILE_SIZE+i)*DATA_WIDTH +: DATA_WIDTH];
                prod = wv * xv;
                dot[l] = dot[l] + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
            end
        end
    end

    always_comb begin
        sel_acc = '0;
        for (int l = 0; l < LANES; l++) begin
            if (lane_cnt == LCW'(l)) sel_acc = acc[l];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = bad_dims ? S_DONE : S_LOAD;
            S_LOAD:  if (w_valid) state_nx = S_MAC;
            S_MAC:   state_nx = tile_last ? S_DRAIN : S_LOAD;
            S_DRAIN: if (!out_valid && drain_end) state_nx = grp_last ? S_DONE : S_LOAD;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Stage p0: tile dot products captured on the weight handshake, added in MAC.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && w_valid) begin
            for (int l = 0; l < LANES; l++) tile_sum_p0[l] <= dot[l];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rows_r    <= '0;
            cols_r    <= '0;
            col_base  <= '0;
            row_base  <= '0;
            lane_cnt  <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rows_r   <= rows;
                        cols_r   <= cols;
                        err      <= bad_dims;
                        col_base <= '0;
                        row_base <= '0;
                        lane_cnt <= '0;
                        for (int l = 0; l < LANES; l++) acc[l] <= '0;
                    end
                end
                S_MAC: begin
                    for (int l = 0; l < LANES; l++) acc[l] <= acc[l] + tile_sum_p0[l];
                    col_base <= tile_last ? 16'd0 : col_base + 16'(TILE_SIZE);
                end
                S_DRAIN: begin
                    if (out_valid) begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            lane_cnt  <= lane_cnt + LCW'(1);
                        end
                    end else if (!drain_end) begin
                        out_valid <= 1'b1;
                        out_data  <= finish_out(sel_acc, bias_arr[RW'(row_cur)]);
                        out_idx   <= row_cur[15:0];
                        out_last  <= (row_cur == ({1'b0, rows_r} - 17'd1));
                    end else begin
                        lane_cnt <= '0;
                        row_base <= row_base + 17'(LANES);
                        for (int l = 0; l < LANES; l++) acc[l] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gemv_lanes.sv
// Directed testbench for gemv_lanes: one task per scenario with hand-computed expected outputs.
module tb_gemv_lanes;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int TS = 32;
    localparam int LN = 4;
    localparam int MR = 1024;
    localparam int MC = 1024;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [15:0]               rows;
    logic [15:0]               cols;
    logic [MC*DW-1:0]          x;
    logic [MR*DW-1:0]          bias;
    logic                      w_valid;
    logic                      w_ready;
    logic [LN*TS*DW-1:0]       w_data;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [AW-1:0]      out_data;
    logic [15:0]               out_idx;
    logic                      out_last;
    logic                      busy;
    logic                      done;
    logic                      err;

    gemv_lanes #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .TILE_SIZE(TS), .LANES(LN),
        .MAX_ROWS(MR), .MAX_COLS(MC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols),
        .x(x), .bias(bias), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic signed [AW-1:0] got_data [16];
    int                   got_idx  [16];
    bit                   got_last [16];
    int n_out, n_tiles, done_cyc;
    bit timed_out, hold_ok, overlap, err_at_done, busy_first;

    task automatic set_x(input int v);
        for (int c = 0; c < MC; c++) x[c*DW +: DW] = DW'(v);
    endtask

    task automatic set_bias_const(input int v);
        for (int r = 0; r < MR; r++) bias[r*DW +: DW] = DW'(v);
    endtask

    task automatic set_bias_row();
        for (int r = 0; r < MR; r++) bias[r*DW +: DW] = DW'(r);
    endtask

    task automatic set_w_const(input int v);
        for (int k = 0; k < LN*TS; k++) w_data[k*DW +: DW] = DW'(v);
    endtask

    task automatic set_w_lane();
        for (int l = 0; l < LN; l++)
            for (int i = 0; i < TS; i++) w_data[(l*TS+i)*DW +: DW] = DW'(l + 1);
    endtask

    // Starts an operation and services both handshakes until done, recording what was seen.
    task automatic run_op(input int nr, input int nc, input int hold);
        int held_left;
        bit first_seen;
        logic signed [AW-1:0] hd;
        logic [15:0] hi;
        n_out = 0; n_tiles = 0; done_cyc = -1; timed_out = 1'b1; hold_ok = 1'b1;
        overlap = 1'b0; err_at_done = 1'b0; busy_first = 1'b0;
        held_left = 0; first_seen = 1'b0; hd = '0; hi = '0;
        rows = 16'(nr); cols = 16'(nc); start = 1'b1; w_valid = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 1) busy_first = busy;
            if (w_ready && out_valid) overlap = 1'b1;
            if (w_ready) n_tiles++;
            if (out_valid && !first_seen && hold > 0) begin
                first_seen = 1'b1; held_left = hold; hd = out_data; hi = out_idx;
            end
            if (held_left > 0) begin
                out_ready = 1'b0;
                if (out_data !== hd || out_idx !== hi || out_valid !== 1'b1 || w_ready !== 1'b0)
                    hold_ok = 1'b0;
                held_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready && n_out < 16) begin
                got_data[n_out] = out_data;
                got_idx[n_out]  = int'(out_idx);
                got_last[n_out] = out_last;
                n_out++;
            end
            if (done) begin
                done_cyc = c; err_at_done = err; timed_out = 1'b0;
                break;
            end
        end
        w_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] ctl;
        rst = 1'b1; start = 1'b0; w_valid = 1'b0; out_ready = 1'b1;
        rows = '0; cols = '0; x = '0; bias = '0; w_data = '0;
        #2;
        ctl = {w_ready, out_valid, out_last, busy, done, err};
        n_vec++; if (ctl !== 6'b0) begin n_miss++; $display("FAIL reset_ctl: got %b want 000000", ctl); end
        n_vec++; if (out_data !== '0) begin n_miss++; $display("FAIL reset_data: got %0d want 0", out_data); end
        n_vec++; if (out_idx !== 16'd0) begin n_miss++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        ctl = {w_ready, out_valid, out_last, busy, done, err};
        n_vec++; if (ctl !== 6'b0) begin n_miss++; $display("FAIL idle_ctl: got %b want 000000", ctl); end
    endtask

    task automatic check_outputs(input string tag, input int nexp, input int base_exp,
                                 input int lane_step, input int bias_step);
        // expected element k: base_exp*(1 + lane_step*(k%LN)) ... computed by caller-specific formula
    endtask

    task automatic test_basic();
        set_w_const(1); set_x(2); set_bias_const(-3);
        run_op(4, 32, 0);
        n_vec++; if (timed_out) begin n_miss++; $display("FAIL basic_done: got timeout want done"); end
        n_vec++; if (busy_first !== 1'b1) begin n_miss++; $display("FAIL basic_busy: got %b want 1", busy_first); end
        n_vec++; if (n_tiles != 1) begin n_miss++; $display("FAIL basic_tiles: got %0d want 1", n_tiles); end
        n_vec++; if (n_out != 4) begin n_miss++; $display("FAIL basic_count: got %0d want 4", n_out); end
        for (int k = 0; k < 4 && k < n_out; k++) begin
            n_vec++;
            if (got_data[k] !== AW'(61) || got_idx[k] != k || got_last[k] != (k == 3)) begin
                n_miss++;
                $display("FAIL basic_elem%0d: got data=%0d idx=%0d last=%0d want data=61 idx=%0d last=%0d",
                         k, got_data[k], got_idx[k], got_last[k], k, (k == 3));
            end
        end
        n_vec++; if (err_at_done !== 1'b0) begin n_miss++; $display("FAIL basic_err: got %b want 0", err_at_done); end
        n_vec++; if (overlap) begin n_miss++; $display("FAIL basic_overlap: got w_ready&out_valid=1 want 0"); end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_miss++; $display("FAIL basic_after: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_two_groups();
        int e;
        set_w_lane(); set_x(1); set_bias_row();
        run_op(5, 40, 0);
        n_vec++; if (n_tiles != 4) begin n_miss++; $display("FAIL grp_tiles: got %0d want 4", n_tiles); end
        n_vec++; if (n_out != 5) begin n_miss++; $display("FAIL grp_count: got %0d want 5", n_out); end
        for (int k = 0; k < 5 && k < n_out; k++) begin
            e = 40 * ((k % LN) + 1) + k;
            n_vec++;
            if (got_data[k] !== AW'(e) || got_idx[k] != k || got_last[k] != (k == 4)) begin
                n_miss++;
                $display("FAIL grp_elem%0d: got data=%0d idx=%0d last=%0d want data=%0d idx=%0d last=%0d",
                         k, got_data[k], got_idx[k], got_last[k], e, k, (k == 4));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        set_w_const(1); set_x(2); set_bias_row();
        run_op(4, 32, 10);
        n_vec++; if (!hold_ok) begin n_miss++; $display("FAIL bp_hold: got unstable output or w_ready want stable"); end
        n_vec++; if (n_out != 4) begin n_miss++; $display("FAIL bp_count: got %0d want 4", n_out); end
        for (int k = 0; k < 4 && k < n_out; k++) begin
            n_vec++;
            if (got_data[k] !== AW'(64 + k) || got_idx[k] != k) begin
                n_miss++;
                $display("FAIL bp_elem%0d: got data=%0d idx=%0d want data=%0d idx=%0d",
                         k, got_data[k], got_idx[k], 64 + k, k);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        int er [2][2];
        er[0][0] = 4;    er[0][1] = 0;
        er[1][0] = 1025; er[1][1] = 32;
        for (int t = 0; t < 2; t++) begin
            run_op(er[t][0], er[t][1], 0);
            n_vec++;
            if (timed_out || done_cyc > 2) begin
                n_miss++; $display("FAIL err%0d_latency: got cycle %0d want <=2", t, done_cyc);
            end
            n_vec++; if (err_at_done !== 1'b1) begin n_miss++; $display("FAIL err%0d_flag: got %b want 1", t, err_at_done); end
            n_vec++; if (n_tiles != 0) begin n_miss++; $display("FAIL err%0d_tiles: got %0d want 0", t, n_tiles); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_extremes();
        int e;
`ifdef GEMV_LANES_RELU_EN
        e = 0;
`else
        e = -520193;
`endif
        set_w_const(-128); set_x(127); set_bias_const(-1);
        run_op(4, 32, 0);
        n_vec++; if (n_out != 4) begin n_miss++; $display("FAIL ext_count: got %0d want 4", n_out); end
        for (int k = 0; k < 4 && k < n_out; k++) begin
            n_vec++;
            if (got_data[k] !== AW'(e)) begin
                n_miss++; $display("FAIL ext_elem%0d: got %0d want %0d", k, got_data[k], e);
            end
        end
        n_vec++; if (err_at_done !== 1'b0) begin n_miss++; $display("FAIL ext_err: got %b want 0", err_at_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        bit found;
        logic [5:0] ctl;
        set_w_const(1); set_x(2); set_bias_const(-3);
        rows = 16'd8; cols = 16'd64; start = 1'b1; w_valid = 1'b1;
        seen = 0; found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (w_ready) seen++;
            if (seen == 2) found = 1'b1;
        end
        n_vec++; if (!found) begin n_miss++; $display("FAIL mid_second_tile: got %0d loads want 2", seen); end
        #2 rst = 1'b1;
        #1;
        ctl = {w_ready, out_valid, out_last, busy, done, err};
        n_vec++; if (ctl !== 6'b0) begin n_miss++; $display("FAIL mid_ctl: got %b want 000000", ctl); end
        n_vec++;
        if (out_data !== '0 || out_idx !== 16'd0) begin
            n_miss++; $display("FAIL mid_out: got data=%0d idx=%0d want 0 0", out_data, out_idx);
        end
        w_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(4, 32, 0);
        n_vec++; if (n_tiles != 1 || n_out != 4) begin n_miss++; $display("FAIL mid_restart: got tiles=%0d outs=%0d want 1 4", n_tiles, n_out); end
        for (int k = 0; k < 4 && k < n_out; k++) begin
            n_vec++;
            if (got_data[k] !== AW'(61) || got_idx[k] != k) begin
                n_miss++; $display("FAIL mid_elem%0d: got data=%0d idx=%0d want 61 %0d", k, got_data[k], got_idx[k], k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_groups();
        test_backpressure();
        test_errors();
        test_extremes();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gemv_lanes.md
GEMV_LANES -- requirements
Module: gemv_lanes

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the signed width of weights, x and bias elements.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, the signed accumulator and output width, constrained to ACC_WIDTH >= 2*DATA_WIDTH+$clog2(MAX_COLS).
REQ-003 SHALL have parameter TILE_SIZE, default 32, the columns per weight tile.
REQ-004 SHALL have parameter LANES, default 4, the number of rows computed in parallel.
REQ-005 SHALL have parameters MAX_ROWS and MAX_COLS, default 1024 each, the largest supported matrix dimensions.
REQ-006 SHALL have port clk, input, 1 bit, the clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port start, input, 1 bit: a one-cycle request to begin an operation.
REQ-009 SHALL have ports rows and cols, input, 16 bits each: the matrix dimensions, sampled on accepted start.
REQ-010 SHALL have port x, input, MAX_COLS*DATA_WIDTH bits: a flat signed vector that is held stable while busy.
REQ-011 SHALL have port bias, input, MAX_ROWS*DATA_WIDTH bits: a flat signed vector that is held stable while busy.
REQ-012 SHALL have ports w_valid (input, 1), w_ready (output, 1) and w_data (input, LANES*TILE_SIZE*DATA_WIDTH): lane l, element i occupy slice (l*TILE_SIZE+i).
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, ACC_WIDTH), out_idx (output, 16) and out_last (output, 1).
REQ-014 SHALL have ports busy, done and err, output, 1 bit each.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD <-> MAC -> DRAIN -> (LOAD | DONE) -> IDLE.
REQ-016 In IDLE, start SHALL be accepted; start SHALL be ignored in every other state.
REQ-017 If rows==0, cols==0, rows>MAX_ROWS or cols>MAX_COLS on accepted start, the block SHALL go to DONE next cycle with err=1 and request no tiles.
REQ-018 A valid start SHALL set busy=1 from the next cycle until the DONE cycle inclusive, clear err, and clear the LANES accumulators.
REQ-019 Row groups SHALL be g=0..ceil(rows/LANES)-1, covering rows g*LANES+l; the block SHALL request ceil(cols/TILE_SIZE) tiles per group, with no packing across rows.
REQ-020 w_ready SHALL be 1 only in LOAD; a tile is transferred when w_valid&&w_ready; the FSM then goes to MAC for exactly one cycle.
REQ-021 In MAC, each lane SHALL add the sum over i of w[l][i]*x[t*TILE_SIZE+i], summed in full precision and accumulated modulo 2^ACC_WIDTH.
REQ-022 Columns >= cols SHALL contribute zero regardless of w_data.
REQ-023 After the last tile of a group, the FSM SHALL enter DRAIN and add sign-extended bias[r] once per valid lane.
REQ-024 DRAIN SHALL present lanes in ascending order with out_idx=row; lanes with row >= rows SHALL be skipped.
REQ-025 out_valid, out_data and out_idx SHALL hold stable until out_ready; an element advances only on out_valid&&out_ready.
REQ-026 out_last SHALL be 1 only with the element for row rows-1.
REQ-027 The first out_valid of a group SHALL occur no later than 2 cycles after the last MAC cycle.
REQ-028 After DRAIN, the FSM SHALL clear the accumulators and return to LOAD for the next group, or go to DONE after the final group.
REQ-029 done SHALL be a one-cycle pulse in the DONE state; the FSM SHALL then return to IDLE.
REQ-030 w_ready and out_valid SHALL never be 1 in the same cycle.

Reset
REQ-031 rst SHALL asynchronously force IDLE and set w_ready=0, out_valid=0, out_last=0, busy=0, done=0 and err=0; out_data, out_idx and the accumulators SHALL be 0.
REQ-032 rst asserted mid-operation SHALL abandon the operation with no done pulse; the next start SHALL begin cleanly.

Configuration
REQ-033 With macro GEMV_LANES_RELU_EN defined, each output SHALL be max(acc+bias, 0) before presentation; without it, the output SHALL be the raw signed acc+bias.

Verification
REQ-034 rows=4, cols=32, all w=1, x=2, bias=-3 -> one tile; outputs idx0..3 = 61; out_last on idx3; done pulse; err=0.
REQ-035 rows=5, cols=40, LANES=4: expect 2 groups x 2 tiles = 4 tile handshakes; cols 40..63 are ignored even when w_data is nonzero there; 5 outputs idx0..4; lanes 5..7 are not emitted.
REQ-036 Hold out_ready=0 for 10 cycles during DRAIN -> out_data and out_idx remain stable, w_ready=0, and no element is lost.
REQ-037 Start with cols=0, and separately with rows=1025 -> err=1 and done on the second cycle after start; no w_ready.
REQ-038 w=-128, x=127, bias=-1, cols=32 -> -520193; with GEMV_LANES_RELU_EN defined -> 0.
REQ-039 Assert rst during the second tile of rows=8 -> outputs reach reset values immediately; a fresh start with rows=4 produces correct results.
